dual_mode_stack: RTL

//   Parametrised successor to the 4-bit/8-deep stack: a single-clock buffer that runs as LIFO (stack)
//   or FIFO (queue), selected at run time. Adds occupancy count, almost-full, push+pop in one cycle,

---
 rtl/buffer_pkg.sv | 18 +
 rtl/buffer_regfile.sv | 31 +++
 rtl/dual_mode_stack.sv | 124 ++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : buffer_pkg                                                  |
// | Brief   : Shared mode encodings and width helpers for buffer blocks.  |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package buffer_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    // Width needed to hold an occupancy value of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : buffer_regfile                                              |
// | Brief   : DEPTH x WIDTH storage, one sync write port, one async read. |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module buffer_regfile #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dual_mode_stack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : dual_mode_stack                                             |
// | Brief   : Run-time selectable LIFO/FIFO buffer with status and errors.|
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module dual_mode_stack
    import buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Mode,
    input  logic                      Push,
    input  logic                      Pop,
    input  logic [WIDTH-1:0]          Data_In,
    output logic [WIDTH-1:0]          Data_Out,
    output logic                      Data_Valid,
    output logic [cnt_w(DEPTH)-1:0]   Count,
    output logic                      Full,
    output logic                      Empty,
    output logic                      Almost_Full,
    output logic                      Overflow,
    output logic                      Underflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

    logic [CW-1:0]    r_count;
    logic             r_mode;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PW-1:0]    w_top_addr;
    logic [PW-1:0]    w_waddr;
    logic [PW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign Empty       = (r_count == '0);
    assign Full        = (r_count == CW'(DEPTH));
    assign Almost_Full = (r_count >= CW'(AF_LEVEL));

    assign w_pop_ok  = Pop & ~Empty;
    assign w_push_ok = Push & (~Full | w_pop_ok);

    // In LIFO mode a simultaneous push overwrites the entry being popped.
    assign w_top_addr = PW'(r_count - CW'(1));
    assign w_waddr    = (r_mode == MODE_FIFO) ? r_wr_ptr
                      : (w_pop_ok ? w_top_addr : PW'(r_count));
    assign w_raddr    = (r_mode == MODE_FIFO) ? r_rd_ptr : w_top_addr;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PW'(1);

    buffer_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_regfile (
        .i_clk   (Clk),
        .i_we    (w_push_ok),
        .i_waddr (w_waddr),
        .i_wdata (Data_In),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count      <= '0;
            r_mode       <= MODE_LIFO;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_overflow   <= Push & Full & ~Pop;
            r_underflow  <= Pop & Empty;
            r_data_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= w_rdata;
            end

            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A mode switch (only possible while empty) restarts the FIFO pointers.
            if (Empty && (Mode != r_mode)) begin
                r_mode   <= Mode;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (r_mode == MODE_FIFO) begin
                if (w_push_ok) r_wr_ptr <= w_wr_ptr_nxt;
                if (w_pop_ok)  r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    assign Data_Out   = r_data_out;
    assign Data_Valid = r_data_valid;
    assign Count      = r_count;
    assign Overflow   = r_overflow;
    assign Underflow  = r_underflow;

endmodule
`default_nettype wire
